// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit BCD up/down counter driving a multiplexed 7-segment display; define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading zeros
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int STEP_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] count,
  output logic        wrap
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int PW = $clog2(STEP_DIV);
  typedef enum logic [1:0] {D0, D1, D2, D3} st_t;
  st_t st, st_n;
  logic [SW-1:0] scp, scp_n;
  logic [PW-1:0] sp;
  logic [15:0] inc, dec;
  logic [3:0] dsel;
  logic step, ld, lz, ci, bi, scan_tc;
  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: pat = 7'b0000001;
      4'd1: pat = 7'b1001111;
      4'd2: pat = 7'b0010010;
      4'd3: pat = 7'b0000110;
      4'd4: pat = 7'b1001100;
      4'd5: pat = 7'b0100100;
      4'd6: pat = 7'b0100000;
      4'd7: pat = 7'b0001111;
      4'd8: pat = 7'b0000000;
      4'd9: pat = 7'b0000100;
      default: pat = 7'b1111111;
    endcase
  endfunction
  assign step = run && sp == PW'(STEP_DIV - 1);
  assign ld = load && load_val[3:0] <= 4'd9 && load_val[7:4] <= 4'd9 &&
              load_val[11:8] <= 4'd9 && load_val[15:12] <= 4'd9;
  always_comb begin
    inc = count;
    dec = count;
    ci = 1'b1;
    bi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inc[4*i +: 4] = ci ? (count[4*i +: 4] == 4'd9 ? 4'd0 : count[4*i +: 4] + 4'd1) : count[4*i +: 4];
      dec[4*i +: 4] = bi ? (count[4*i +: 4] == 4'd0 ? 4'd9 : count[4*i +: 4] - 4'd1) : count[4*i +: 4];
      ci = ci && count[4*i +: 4] == 4'd9;
      bi = bi && count[4*i +: 4] == 4'd0;
    end
  end
  // a valid load wins over a coincident step and restarts the step prescaler
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      sp <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= !ld && step && (up ? count == 16'h9999 : count == 16'h0000);
      if (ld) begin
        count <= load_val;
        sp <= '0;
      end else if (run) begin
        sp <= step ? '0 : sp + 1'b1;
        if (step) count <= up ? inc : dec;
      end
    end
  end
  assign scan_tc = scp == SW'(SCAN_DIV - 1);
  assign scp_n = scan_tc ? '0 : scp + 1'b1;
  always_ff @(posedge clk) st <= rst ? D0 : st_n;
  always_comb st_n = scan_tc ? st_t'(st + 2'd1) : st;
  assign dsel = count[{st_n, 2'b00} +: 4];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  assign lz = (st_n == D3 && count[15:12] == 4'd0) || (st_n == D2 && count[15:8] == 8'd0) ||
              (st_n == D1 && count[15:4] == 12'd0);
`else
  assign lz = 1'b0;
`endif
  // outputs are registered from the upcoming slot so an and seg switch together
  always_ff @(posedge clk) begin
    if (rst) begin
      scp <= '0;
      an <= 4'hF;
      seg <= 7'h7F;
    end else begin
      scp <= scp_n;
      an <= scp_n == '0 ? 4'hF : ~(4'b0001 << st_n);
      seg <= lz ? 7'h7F : pat(dsel);
    end
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit scan slot (legal values >= 2).
REQ-002 SHALL have parameter STEP_DIV, default 25000000: clk cycles per count step while running (legal values >= 2).
REQ-003 SHALL have port clk  input  1  rising-edge system clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run  input  1  level; 1 = counting enabled.
REQ-006 SHALL have port up  input  1  level; 1 = count up, 0 = count down.
REQ-007 SHALL have port load  input  1  single-cycle pulse that loads load_val.
REQ-008 SHALL have port load_val  input  16  four BCD digits; [3:0] is the least significant digit.
REQ-009 SHALL have port seg  output  7  active-low segments, bit6=a through bit0=g.
REQ-010 SHALL have port an  output  4  active-low digit enables; an[0] is the least significant digit.
REQ-011 SHALL have port count  output  16  current BCD value.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse on 9999->0000 or 0000->9999.

Function
REQ-013 Step prescaler SHALL count 0..STEP_DIV-1 while run=1, hold while run=0, and produce a step at terminal count before returning to 0.
REQ-014 On a step, count SHALL change at that same clk edge: +1 BCD if up=1, -1 BCD if up=0, with per-digit carry/borrow.
REQ-015 Counter SHALL wrap 9999->0000 (up) and 0000->9999 (down), with wrap=1 for exactly the following cycle and 0 otherwise.
REQ-016 load=1 with every load_val digit <=9 SHALL set count=load_val at the next edge, clear the step prescaler, and suppress any coincident step and wrap.
REQ-017 load=1 with any load_val digit >9 SHALL be ignored entirely: count and the prescaler are unchanged.
REQ-018 Scan prescaler SHALL free-run 0..SCAN_DIV-1, independent of run and load.
REQ-019 Scan FSM SHALL have states D0->D1->D2->D3->D0, advancing when the scan prescaler is at terminal count.
REQ-020 In state Dn, an SHALL be 1111 for the first cycle of the slot (anti-ghost blank), then have only an[n] low for the remaining SCAN_DIV-1 cycles.
REQ-021 seg SHALL show digit n of the current count, registered and updating in the same cycle as an.
REQ-022 Segment patterns for digits 0-9 SHALL be: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
REQ-023 A count change mid-slot SHALL appear on seg at the next clk edge, without waiting for a slot boundary.

Reset
REQ-024 rst SHALL set count=0000, wrap=0, both prescalers=0, FSM=D0, an=1111, seg=1111111, and takes priority over load and run.
REQ-025 The first cycle after rst deasserts SHALL be the D0 blank cycle, with an[0] going low the cycle after that.
REQ-026 rst asserted mid-slot or mid-step SHALL abandon that operation, with no wrap pulse and no partial update.

Configuration
REQ-027 With macro SEG_SCAN_LEADING_ZERO_BLANK_EN defined, a digit n>0 that is 0 with all higher digits 0 SHALL drive seg=1111111 while its an bit still scans; digit 0 is always displayed.
REQ-028 Without SEG_SCAN_LEADING_ZERO_BLANK_EN, all four digits SHALL always be displayed, including leading zeros.

Verification (SCAN_DIV=4, STEP_DIV=8)
REQ-029 Release rst, with run=0 -> an sequence 1111,1110,1110,1110,1111,1101,... and seg=0000001 in every D0 cycle.
REQ-030 load=1, load_val=0x9998, run=1, up=1 -> count 9999 after 8 cycles, 0000 after 16 cycles with wrap high for exactly 1 cycle.
REQ-031 load 0x0000, up=0, run=1 -> count 9999 after 8 cycles with wrap pulse; load 0x0100 and step down -> 0099 via borrow.
REQ-032 load 0x12A4 -> count unchanged, no wrap; load 0x0042 on a step-terminal cycle -> count 0042 and prescaler restarts from 0.
REQ-033 Assert rst during a D2 slot and at step terminal count -> next cycle matches REQ-024 with wrap=0.
REQ-034 With SEG_SCAN_LEADING_ZERO_BLANK_EN, count 0007 -> seg=1111111 in D3/D2/D1 and 0001111 in D0; without the macro -> D1-D3 show 0000001.
